// File: rtl/conv_6_pkg.sv
// Shared constants, rounding/saturation helpers and FSM state type for the conv_6 datapath.
package conv_6_pkg;

  localparam int unsigned DEF_PROD_WIDTH = 24;
  localparam int unsigned DEF_ACC_WIDTH  = 32;
  localparam int unsigned DEF_OUT_WIDTH  = 16;

  function automatic longint sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Half an output LSB, added before the arithmetic shift for round-half-up.
  function automatic longint round_const(input int unsigned shift);
    return 64'sd1 <<< (shift - 1);
  endfunction

  localparam longint SAT_MAX = sat_max(DEF_OUT_WIDTH);
  localparam longint SAT_MIN = sat_min(DEF_OUT_WIDTH);

  typedef enum logic [0:0] {
    StFirst,
    StRun
  } state_e;

endpackage

// File: rtl/conv_6_acc_sat_if.sv
// Product-in / result-out handshake bundle of the conv_6 accumulator.
interface conv_6_acc_sat_if
  import conv_6_pkg::*;
#(
  parameter int unsigned PROD_WIDTH = DEF_PROD_WIDTH,
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH
);

  logic signed [OUT_WIDTH-1:0]  bias;
  logic                         prod_valid;
  logic                         prod_ready;
  logic signed [PROD_WIDTH-1:0] prod_data;
  logic                         res_valid;
  logic                         res_ready;
  logic signed [OUT_WIDTH-1:0]  res_data;
  logic                         res_sat;
  logic                         busy;

  modport master (
    output bias, prod_valid, prod_data, res_ready,
    input  prod_ready, res_valid, res_data, res_sat, busy
  );

  modport slave (
    input  bias, prod_valid, prod_data, res_ready,
    output prod_ready, res_valid, res_data, res_sat, busy
  );

endinterface

// File: rtl/conv_6_acc_sat_round.sv
// Combinational round-half-up, arithmetic right shift and saturation of an accumulator value.
module conv_6_acc_sat_round
  import conv_6_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int unsigned SHIFT     = 8
) (
  input  logic signed [ACC_WIDTH-1:0] s,
  output logic signed [OUT_WIDTH-1:0] res,
  output logic                        sat
);

  // One guard bit so the rounding increment never wraps.
  localparam int unsigned W = ACC_WIDTH + 1;
  localparam logic signed [W-1:0] RndK = W'(round_const(SHIFT));
  localparam logic signed [W-1:0] MaxV = W'(sat_max(OUT_WIDTH));
  localparam logic signed [W-1:0] MinV = W'(sat_min(OUT_WIDTH));

  logic signed [W-1:0] rounded;
  logic signed [W-1:0] shifted;

  always_comb begin
    rounded = W'(s) + RndK;
    shifted = rounded >>> SHIFT;
    res     = shifted[OUT_WIDTH-1:0];
    sat     = 1'b0;
    if (shifted > MaxV) begin
      res = MaxV[OUT_WIDTH-1:0];
      sat = 1'b1;
    end else if (shifted < MinV) begin
      res = MinV[OUT_WIDTH-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/conv_6_acc_sat.sv
// Windowed product accumulator with bias, rounding, saturation and a single-entry result register.
module conv_6_acc_sat
  import conv_6_pkg::*;
#(
  parameter int unsigned PROD_WIDTH = DEF_PROD_WIDTH,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int unsigned N_TERMS    = 9,
  parameter int unsigned SHIFT      = 8
) (
  input logic             ap_clk,
  input logic             ap_rst,
  conv_6_acc_sat_if.slave bus
);

  localparam int unsigned CntW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

  state_e                       state_q, state_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         res_valid_q;
  logic signed [OUT_WIDTH-1:0]  res_data_q;
  logic                         res_sat_q;

  logic                         prod_ready;
  logic                         xfer;
  logic                         last;
  logic                         load;
  logic signed [ACC_WIDTH-1:0]  acc_base;
  logic signed [OUT_WIDTH-1:0]  rnd_res;
  logic                         rnd_sat;

  assign prod_ready = !res_valid_q || bus.res_ready;
  assign xfer       = bus.prod_valid && prod_ready;
  assign last       = (cnt_q == CntW'(N_TERMS - 1));
  assign load       = xfer && last;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    acc_base = (state_q == StFirst) ? (ACC_WIDTH'($signed(bus.bias)) <<< SHIFT) : acc_q;
    if (xfer) begin
      acc_d = acc_base + ACC_WIDTH'($signed(bus.prod_data));
      if (last) begin
        cnt_d   = '0;
        state_d = StFirst;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = StRun;
      end
    end
  end

  // Fed with the next-state sum so the result is ready on the last accepting edge.
  conv_6_acc_sat_round #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT)
  ) u_round (
    .s   (acc_d),
    .res (rnd_res),
    .sat (rnd_sat)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= StFirst;
      cnt_q       <= '0;
      acc_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      if (load) begin
        res_valid_q <= 1'b1;
        res_data_q  <= rnd_res;
        res_sat_q   <= rnd_sat;
      end else if (bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.prod_ready = prod_ready;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_sat    = res_sat_q;
  assign bus.busy       = (cnt_q != '0);

endmodule

// File: tb/tb_conv_6_acc_sat.sv
// Scoreboard bench for conv_6_acc_sat: directed windows push expected results, a monitor pops them.
module tb_conv_6_acc_sat;
  import conv_6_pkg::*;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  conv_6_acc_sat_if #(.PROD_WIDTH(24), .OUT_WIDTH(16)) bus ();

  conv_6_acc_sat #(
    .PROD_WIDTH (24),
    .ACC_WIDTH  (32),
    .OUT_WIDTH  (16),
    .N_TERMS    (9),
    .SHIFT      (8)
  ) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus.slave)
  );

  typedef struct packed {
    logic signed [15:0] data;
    logic               sat;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input logic signed [15:0] d, input logic s);
    exp_t e;
    e.data = d;
    e.sat  = s;
    q.push_back(e);
  endtask

  // Holds one product until accepted; bounded wait.
  task automatic send(input logic signed [15:0] b, input logic signed [23:0] d);
    bit acc;
    int n;
    bus.prod_valid = 1'b1;
    bus.prod_data  = d;
    bus.bias       = b;
    n = 0;
    do begin
      @(negedge ap_clk);
      acc = bus.prod_ready;
      @(posedge ap_clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end
  endtask

  // Bias on later taps is junk on purpose: only the first tap's bias may count.
  task automatic window(input logic signed [15:0] b, input logic signed [23:0] d0,
                        input logic signed [23:0] drest);
    send(b, d0);
    for (int i = 1; i < 9; i++) send(16'sd77, drest);
  endtask

  task automatic idle(input int n);
    bus.prod_valid = 1'b0;
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst && bus.res_valid && bus.res_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=%0d required=none", bus.res_data);
        end else begin
          e = q.pop_front();
          chk("res_data", longint'(bus.res_data), longint'(e.data));
          chk("res_sat", longint'(bus.res_sat), longint'(e.sat));
        end
      end
    end
  end

  initial begin
    int n;
    bus.prod_valid = 1'b0;
    bus.prod_data  = '0;
    bus.bias       = '0;
    bus.res_ready  = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;

    chk("rst_res_valid", longint'(bus.res_valid), 0);
    chk("rst_res_data", longint'(bus.res_data), 0);
    chk("rst_res_sat", longint'(bus.res_sat), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_prod_ready", longint'(bus.prod_ready), 1);

    // 900 -> (900+128)>>>8 = 4
    push(16'sd4, 1'b0);
    window(16'sd0, 24'sd100, 24'sd100);
    chk("latency_valid", longint'(bus.res_valid), 1);
    idle(2);

    push(-16'sd3, 1'b0);
    window(-16'sd3, 24'sd0, 24'sd0);
    idle(2);

    push(16'sd32767, 1'b1);
    window(16'sd0, 24'sd8388607, 24'sd8388607);
    idle(2);

    push(-16'sd32768, 1'b1);
    window(16'sd0, -24'sd8388608, -24'sd8388608);
    idle(2);

    push(16'sd0, 1'b0);
    window(16'sd0, -24'sd128, 24'sd0);
    idle(2);

    push(-16'sd1, 1'b0);
    window(16'sd0, -24'sd129, 24'sd0);
    idle(2);

    // Back-to-back: second window (bias 1, 9x256) -> 2560 -> 10
    push(16'sd4, 1'b0);
    push(16'sd10, 1'b0);
    window(16'sd0, 24'sd100, 24'sd100);
    window(16'sd1, 24'sd256, 24'sd256);
    idle(2);

    // Backpressure: 9x512 -> 18 held; next window (bias -1, 9x256) -> 2048 -> 8
    bus.res_ready = 1'b0;
    push(16'sd18, 1'b0);
    push(16'sd8, 1'b0);
    window(16'sd0, 24'sd512, 24'sd512);
    bus.prod_valid = 1'b1;
    bus.prod_data  = 24'sd256;
    bus.bias       = -16'sd1;
    repeat (3) begin
      @(negedge ap_clk);
      chk("stall_prod_ready", longint'(bus.prod_ready), 0);
      chk("stall_busy", longint'(bus.busy), 0);
      chk("stall_res_valid", longint'(bus.res_valid), 1);
    end
    @(posedge ap_clk);
    #1;
    bus.res_ready = 1'b1;
    window(-16'sd1, 24'sd256, 24'sd256);
    idle(2);

    // Reset mid-window discards 4x1000
    for (int i = 0; i < 4; i++) send(16'sd0, 24'sd1000);
    bus.prod_valid = 1'b0;
    chk("pre_rst_busy", longint'(bus.busy), 1);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    chk("post_rst_busy", longint'(bus.busy), 0);
    chk("post_rst_res_valid", longint'(bus.res_valid), 0);
    push(16'sd9, 1'b0);
    window(16'sd0, 24'sd256, 24'sd256);
    idle(1);

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge ap_clk);
      n++;
    end
    chk("queue_empty", longint'(q.size()), 0);
    repeat (2) @(posedge ap_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
